// File: rtl/gpu_pkg.sv
// Shared GPU definitions: register width, memory address width and the
// memory-write request record carried from the ALU to the data memory.
package gpu_pkg;

    localparam int REG_WIDTH      = 32;
    localparam int MEM_ADDR_WIDTH = 16;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [REG_WIDTH-1:0]      data;
    } mem_write_req_s;

endpackage

// File: rtl/write_buf_match.sv
// Youngest-match search over the write buffer entries: walks from the oldest
// entry (rd_ptr) forward so the last valid match found is the youngest store.
module write_buf_match
    import gpu_pkg::*;
#(
    parameter int addr_width = MEM_ADDR_WIDTH,
    parameter int width      = REG_WIDTH,
    parameter int depth      = 4
) (
    input  logic [depth-1:0][addr_width-1:0] entry_addr,
    input  logic [depth-1:0][width-1:0]      entry_data,
    input  logic [depth-1:0]                 entry_valid,
    input  logic [$clog2(depth)-1:0]         rd_ptr,
    input  logic [addr_width-1:0]            lookup_addr,
    output logic                             hit,
    output logic [width-1:0]                 hit_data
);

    localparam int ptr_width = $clog2(depth);

    logic [depth-1:0]     match;
    logic [ptr_width-1:0] idx;

    generate
        for (genvar gi = 0; gi < depth; gi++) begin : g_match
            assign match[gi] = entry_valid[gi] && (entry_addr[gi] == lookup_addr);
        end
    endgenerate

    // Valid entries are contiguous from rd_ptr, so later hits are younger.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = rd_ptr;
        for (int k = 0; k < depth; k++) begin
            idx = rd_ptr + k[ptr_width-1:0];
            if (match[idx]) begin
                hit      = 1'b1;
                hit_data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/mem_write_buffer.sv
// In-order store buffer between the ALU write channel and data memory, with a
// registered lookup port that forwards data from stores not yet committed.
module mem_write_buffer
    import gpu_pkg::*;
#(
    parameter int mem_addr_width = MEM_ADDR_WIDTH,
    parameter int width          = REG_WIDTH,
    parameter int depth          = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        w_valid_i,
    input  logic [mem_addr_width-1:0]   w_addr_i,
    input  logic [width-1:0]            w_data_i,
    output logic                        w_ready_o,
    output logic                        mem_we_o,
    output logic [mem_addr_width-1:0]   mem_addr_o,
    output logic [width-1:0]            mem_data_o,
    input  logic                        mem_ready_i,
    input  logic                        r_valid_i,
    input  logic [mem_addr_width-1:0]   r_addr_i,
    output logic                        r_hit_o,
    output logic [width-1:0]            r_data_o,
    output logic [$clog2(depth):0]      count_o,
    output logic                        empty_o
);

    localparam int ptr_width = $clog2(depth);
    localparam int cnt_width = ptr_width + 1;
    localparam logic [cnt_width-1:0] full_count = cnt_width'(depth);

    logic [depth-1:0][mem_addr_width-1:0] addr_mem;
    logic [depth-1:0][width-1:0]          data_mem;

    logic [depth-1:0]     valid_reg, valid_next;
    logic [ptr_width-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ptr_width-1:0] wr_ptr_reg, wr_ptr_next;
    logic [cnt_width-1:0] count_reg, count_next;
    logic                 r_hit_reg, r_hit_next;
    logic [width-1:0]     r_data_reg, r_data_next;

    logic             push;
    logic             pop;
    logic             match_hit;
    logic [width-1:0] match_data;

    assign w_ready_o  = (count_reg != full_count);
    assign mem_we_o   = (count_reg != '0);
    assign empty_o    = (count_reg == '0);
    assign count_o    = count_reg;
    assign mem_addr_o = addr_mem[rd_ptr_reg];
    assign mem_data_o = data_mem[rd_ptr_reg];
    assign r_hit_o    = r_hit_reg;
    assign r_data_o   = r_data_reg;

    assign push = w_valid_i && w_ready_o;
    assign pop  = mem_we_o && mem_ready_i;

    write_buf_match #(
        .addr_width (mem_addr_width),
        .width      (width),
        .depth      (depth)
    ) u_match (
        .entry_addr  (addr_mem),
        .entry_data  (data_mem),
        .entry_valid (valid_reg),
        .rd_ptr      (rd_ptr_reg),
        .lookup_addr (r_addr_i),
        .hit         (match_hit),
        .hit_data    (match_data)
    );

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        valid_next  = valid_reg;
        r_hit_next  = 1'b0;
        r_data_next = r_data_reg;

        if (pop) begin
            rd_ptr_next            = rd_ptr_reg + ptr_width'(1);
            valid_next[rd_ptr_reg] = 1'b0;
        end
        if (push) begin
            wr_ptr_next            = wr_ptr_reg + ptr_width'(1);
            valid_next[wr_ptr_reg] = 1'b1;
        end
        if (push && !pop) begin
            count_next = count_reg + cnt_width'(1);
        end else if (pop && !push) begin
            count_next = count_reg - cnt_width'(1);
        end

        // The store arriving this cycle is younger than anything already held.
        if (r_valid_i) begin
            if (push && (w_addr_i == r_addr_i)) begin
                r_hit_next  = 1'b1;
                r_data_next = w_data_i;
            end else if (match_hit) begin
                r_hit_next  = 1'b1;
                r_data_next = match_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
            r_hit_reg  <= 1'b0;
            r_data_reg <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            valid_reg  <= valid_next;
            r_hit_reg  <= r_hit_next;
            r_data_reg <= r_data_next;
        end
    end

    // Entry payloads need no reset; the valid bits and count gate their use.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= w_addr_i;
            data_mem[wr_ptr_reg] <= w_data_i;
        end
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Randomized and directed checks of mem_write_buffer against a queue-based
// model of pending stores.
module tb_mem_write_buffer;
    import gpu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        w_valid_i = 1'b0;
    logic [15:0] w_addr_i = '0;
    logic [31:0] w_data_i = '0;
    logic        w_ready_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_ready_i = 1'b0;
    logic        r_valid_i = 1'b0;
    logic [15:0] r_addr_i = '0;
    logic        r_hit_o;
    logic [31:0] r_data_o;
    logic [2:0]  count_o;
    logic        empty_o;

    mem_write_buffer #(
        .mem_addr_width (16),
        .width          (32),
        .depth          (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .w_valid_i   (w_valid_i),
        .w_addr_i    (w_addr_i),
        .w_data_i    (w_data_i),
        .w_ready_o   (w_ready_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_ready_i (mem_ready_i),
        .r_valid_i   (r_valid_i),
        .r_addr_i    (r_addr_i),
        .r_hit_o     (r_hit_o),
        .r_data_o    (r_data_o),
        .count_o     (count_o),
        .empty_o     (empty_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    bit verbose = 1'b1;

    mem_write_req_s pend_q[$];
    logic        m_hit = 1'b0;
    logic [31:0] m_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [31:0] d,
                         input logic mr, input logic rv, input logic [15:0] ra);
        w_valid_i   = v;
        w_addr_i    = a;
        w_data_i    = d;
        mem_ready_i = mr;
        r_valid_i   = rv;
        r_addr_i    = ra;
    endtask

    // Compare outputs with the model, advance the model by one clock, then the DUT.
    task automatic step();
        bit             do_push;
        bit             found;
        mem_write_req_s req;
        check("w_ready", 32'(w_ready_o), 32'(pend_q.size() < DEPTH));
        check("mem_we", 32'(mem_we_o), 32'(pend_q.size() != 0));
        if (pend_q.size() != 0) begin
            check("mem_addr", 32'(mem_addr_o), 32'(pend_q[0].addr));
            check("mem_data", mem_data_o, pend_q[0].data);
        end
        check("count", 32'(count_o), 32'(pend_q.size()));
        check("empty", 32'(empty_o), 32'(pend_q.size() == 0));
        check("r_hit", 32'(r_hit_o), 32'(m_hit));
        check("r_data", r_data_o, m_data);

        if (reset_i) begin
            pend_q.delete();
            m_hit  = 1'b0;
            m_data = '0;
        end else begin
            do_push = w_valid_i && (pend_q.size() < DEPTH);
            if (r_valid_i) begin
                found = 1'b0;
                if (do_push && w_addr_i == r_addr_i) begin
                    found  = 1'b1;
                    m_data = w_data_i;
                end else begin
                    for (int i = pend_q.size() - 1; i >= 0 && !found; i--) begin
                        if (pend_q[i].addr == r_addr_i) begin
                            found  = 1'b1;
                            m_data = pend_q[i].data;
                        end
                    end
                end
                m_hit = found;
            end else begin
                m_hit = 1'b0;
            end
            if (pend_q.size() != 0 && mem_ready_i) begin
                if (verbose)
                    $display("commit addr=%04h data=%08h", pend_q[0].addr, pend_q[0].data);
                void'(pend_q.pop_front());
            end
            if (do_push) begin
                req.addr = w_addr_i;
                req.data = w_data_i;
                pend_q.push_back(req);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    // Hold a store on the write channel until the buffer accepts it.
    task automatic push_wait(input logic [15:0] a, input logic [31:0] d, input logic mr);
        bit accepted = 1'b0;
        for (int n = 0; n < 20 && !accepted; n++) begin
            drive(1'b1, a, d, mr, 1'b0, '0);
            accepted = w_ready_o;
            step();
        end
        check("push_accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        drive(1'b0, '0, '0, 1'b1, 1'b0, '0);
        while (pend_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(pend_q.size()), 32'd0);
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        step();
        reset_i = 1'b0;
        check("reset_we", 32'(mem_we_o), 32'd0);
        check("reset_ready", 32'(w_ready_o), 32'd1);
        check("reset_empty", 32'(empty_o), 32'd1);

        // Single store: visible the following cycle, gone one cycle later.
        drive(1'b1, 16'h0010, 32'h1111_1111, 1'b1, 1'b0, '0);
        step();
        check("first_we", 32'(mem_we_o), 32'd1);
        check("first_addr", 32'(mem_addr_o), 32'h0010);
        check("first_data", mem_data_o, 32'h1111_1111);
        drive(1'b0, '0, '0, 1'b1, 1'b0, '0);
        step();
        check("first_empty", 32'(empty_o), 32'd1);

        // Fill while memory stalls, then release with the 5th store held.
        for (int i = 0; i < 4; i++)
            push_wait(16'h0100 + 16'(i), 32'hA000_0000 + 32'(i), 1'b0);
        check("full_ready", 32'(w_ready_o), 32'd0);
        check("full_count", 32'(count_o), 32'd4);
        drive(1'b1, 16'h0104, 32'hA000_0004, 1'b0, 1'b0, '0);
        step();
        step();
        check("stall_head", 32'(mem_addr_o), 32'h0100);
        push_wait(16'h0104, 32'hA000_0004, 1'b1);
        drain(20);

        // Forwarding: youngest duplicate wins, miss, and same-cycle push.
        push_wait(16'h0020, 32'h0000_000A, 1'b0);
        push_wait(16'h0020, 32'h0000_000B, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 16'h0020);
        step();
        check("fwd_hit", 32'(r_hit_o), 32'd1);
        check("fwd_data", r_data_o, 32'h0000_000B);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 16'h0024);
        step();
        check("fwd_miss", 32'(r_hit_o), 32'd0);
        check("fwd_miss_hold", r_data_o, 32'h0000_000B);
        drive(1'b1, 16'h0030, 32'h0000_000C, 1'b0, 1'b1, 16'h0030);
        step();
        check("fwd_push_hit", 32'(r_hit_o), 32'd1);
        check("fwd_push_data", r_data_o, 32'h0000_000C);

        // Reset with three pending discards them.
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_hit", 32'(r_hit_o), 32'd0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_no_write", 32'(mem_we_o), 32'd0);
        end

        // Randomized traffic over a small address set to provoke hits.
        verbose = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 9) < 6, 16'h0040 + 16'($urandom_range(0, 5) * 4),
                  $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  16'h0040 + 16'($urandom_range(0, 6) * 4));
            reset_i = ($urandom_range(0, 99) == 0);
            step();
        end
        reset_i = 1'b0;
        verbose = 1'b1;
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
